// File: rtl/gesture_pkg.sv
// Shared definitions for the finger-count gesture path: the extractor,
// the count filter and the arm command mapper all use these.
package gesture_pkg;

    // Default count width and largest legal finger count
    localparam int GESTURE_COUNT_W   = 3;
    localparam int GESTURE_MAX_COUNT = 5;

    // Filter FSM: idle (nothing accepted), locked (candidate matches the
    // accepted count), pending (a different candidate is building a run)
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOCKED  = 2'd1,
        S_PENDING = 2'd2
    } gesture_state_e;

    // Larger of two integers, used to size the run counter
    function automatic int gesture_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frame_watchdog.sv
// Frame watchdog: counts cycles with no frame while enabled and strobes
// expire on the cycle the count would reach TIMEOUT_CYCLES. A frame in that
// same cycle clears the count, so the frame always wins over the timeout.
// TIMEOUT_CYCLES=0 disables expiry entirely.
module frame_watchdog #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam bit ACTIVE = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W  = ACTIVE ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACTIVE ? TIMEOUT_CYCLES - 1 : 0);

    logic [CNT_W-1:0] idle_cnt;

    assign expire = ACTIVE && enable && !clear && (idle_cnt == LAST);

    // Idle counter: zero while disabled, on any frame and on expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt <= '0;
        else if (!ACTIVE || clear || expire || !enable)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end

endmodule

// File: rtl/gesture_count_filter.sv
// Temporal filter for the per-frame finger count. A count is accepted after
// a run of identical legal frames (longer run for zero), out-of-range frames
// are rejected and break the run, and a frame gap forces the output idle.
module gesture_count_filter
    import gesture_pkg::*;
#(
    parameter int COUNT_W        = GESTURE_COUNT_W,
    parameter int MAX_COUNT      = GESTURE_MAX_COUNT,
    parameter int STABLE_FRAMES  = 5,
    parameter int ZERO_FRAMES    = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COUNT_W-1:0] raw_count,
    input  logic               count_valid,
    output logic [COUNT_W-1:0] stable_count,
    output logic               stable_valid,
    output logic               change_pulse,
    output logic               timeout_pulse,
    output logic               reject_pulse
);

    localparam int RUN_MAX = gesture_max(STABLE_FRAMES, ZERO_FRAMES);
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    localparam logic [RUN_W-1:0]   RUN_SAT  = RUN_W'(RUN_MAX);
    localparam logic [RUN_W-1:0]   T_STABLE = RUN_W'(STABLE_FRAMES);
    localparam logic [RUN_W-1:0]   T_ZERO   = RUN_W'(ZERO_FRAMES);
    localparam logic [COUNT_W-1:0] MAX_V    = COUNT_W'(MAX_COUNT);

    gesture_state_e     state;
    logic [COUNT_W-1:0] cand;
    logic [RUN_W-1:0]   run;

    logic               in_range;
    logic               same;
    logic [RUN_W-1:0]   run_nx;
    logic [RUN_W-1:0]   thr;
    logic               accept;
    logic               expire;

    frame_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (count_valid),
        .enable (stable_valid),
        .expire (expire)
    );

    // Next run length and acceptance decision for the incoming frame
    always_comb begin
        in_range = (raw_count <= MAX_V);
        same     = (raw_count == cand) && (run != '0);
        run_nx   = RUN_W'(1);
        if (same)
            run_nx = (run == RUN_SAT) ? run : run + 1'b1;
        thr      = (raw_count == '0) ? T_ZERO : T_STABLE;
        // Only the exact threshold crossing accepts, so a long run pulses once
        accept   = count_valid && in_range && (run_nx == thr) &&
                   ((state == S_IDLE) || (raw_count != stable_count));
    end

    // Candidate tracking, acceptance, rejection and timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cand          <= '0;
            run           <= '0;
            stable_count  <= '0;
            stable_valid  <= 1'b0;
            change_pulse  <= 1'b0;
            timeout_pulse <= 1'b0;
            reject_pulse  <= 1'b0;
        end else begin
            change_pulse  <= 1'b0;
            timeout_pulse <= 1'b0;
            reject_pulse  <= 1'b0;
            if (count_valid) begin
                if (!in_range) begin
                    // Bad frame breaks the run but keeps the candidate value
                    reject_pulse <= 1'b1;
                    run          <= '0;
                end else begin
                    cand <= raw_count;
                    run  <= run_nx;
                    if (accept) begin
                        stable_count <= raw_count;
                        stable_valid <= 1'b1;
                        change_pulse <= 1'b1;
                        state        <= S_LOCKED;
                    end else if (state == S_LOCKED && raw_count != stable_count) begin
                        state <= S_PENDING;
                    end else if (state == S_PENDING && raw_count == stable_count) begin
                        state <= S_LOCKED;
                    end
                end
            end else if (expire) begin
                stable_count  <= '0;
                stable_valid  <= 1'b0;
                cand          <= '0;
                run           <= '0;
                timeout_pulse <= 1'b1;
                state         <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_gesture_count_filter.sv
// Scoreboard bench for gesture_count_filter: every driven cycle pushes the
// outputs expected after the next clock edge; a monitor pops and compares.
module tb_gesture_count_filter;

    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] raw_count;
    logic          count_valid;
    logic [CW-1:0] stable_count;
    logic          stable_valid;
    logic          change_pulse;
    logic          timeout_pulse;
    logic          reject_pulse;

    gesture_count_filter #(
        .COUNT_W        (CW),
        .MAX_COUNT      (5),
        .STABLE_FRAMES  (5),
        .ZERO_FRAMES    (8),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .raw_count     (raw_count),
        .count_valid   (count_valid),
        .stable_count  (stable_count),
        .stable_valid  (stable_valid),
        .change_pulse  (change_pulse),
        .timeout_pulse (timeout_pulse),
        .reject_pulse  (reject_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    cnt;
        int    vld;
        int    chg;
        int    to;
        int    rej;
        string tag;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   e_cnt = 0;
    int   e_vld = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle and queue the outputs expected after its edge
    task automatic drive(input bit vld, input int v, input bit chg,
                         input bit to, input bit rej, input string tag);
        exp_t e;
        @(negedge clk);
        count_valid = vld;
        raw_count   = CW'(v);
        e.cnt = e_cnt; e.vld = e_vld; e.chg = chg; e.to = to; e.rej = rej;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic frame(input int v, input bit acc, input bit rej, input string tag);
        if (acc) begin
            e_cnt = v;
            e_vld = 1;
        end
        drive(1'b1, v, acc, 1'b0, rej, tag);
    endtask

    // n cycles without frames; timeout expected on cycle to_at (0 = never)
    task automatic gap(input int n, input int to_at, input string tag);
        for (int i = 1; i <= n; i++) begin
            if (i == to_at) begin
                e_cnt = 0;
                e_vld = 0;
            end
            drive(1'b0, 0, 1'b0, (i == to_at), 1'b0, tag);
        end
    endtask

    // Five identical frames from a state where v is not already accepted
    task automatic lock(input int v, input string tag);
        for (int i = 1; i <= 5; i++)
            frame(v, (i == 5), 1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        exp_t e;
        @(negedge clk);
        rst_n       = 1'b0;
        count_valid = 1'b0;
        raw_count   = '0;
        e_cnt = 0; e_vld = 0;
        e.cnt = 0; e.vld = 0; e.chg = 0; e.to = 0; e.rej = 0; e.tag = tag;
        sbq.push_back(e);
        @(negedge clk);
        rst_n = 1'b1;
        sbq.push_back(e);
    endtask

    // Monitor: sample just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.tag, ".stable_count"},  int'(stable_count),  e.cnt);
                chk({e.tag, ".stable_valid"},  int'(stable_valid),  e.vld);
                chk({e.tag, ".change_pulse"},  int'(change_pulse),  e.chg);
                chk({e.tag, ".timeout_pulse"}, int'(timeout_pulse), e.to);
                chk({e.tag, ".reject_pulse"},  int'(reject_pulse),  e.rej);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL sim_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int seq2[10];
        int seq4[8];
        rst_n       = 1'b0;
        count_valid = 1'b0;
        raw_count   = '0;
        do_reset("reset");

        // Accept 3 after five frames; sixth frame of 3 gives no pulse
        lock(3, "acc3");
        frame(3, 1'b0, 1'b0, "acc3_hold");

        // Interrupted run of 2s, accepted on the fifth consecutive 2
        seq2 = '{2, 2, 2, 2, 3, 2, 2, 2, 2, 2};
        for (int i = 0; i < 10; i++)
            frame(seq2[i], (i == 9), 1'b0, "run2");

        // Zero needs eight frames
        lock(4, "acc4");
        for (int i = 1; i <= 8; i++)
            frame(0, (i == 8), 1'b0, "zero");

        // Out-of-range frame breaks the run of 5s
        lock(1, "acc1");
        seq4 = '{5, 5, 6, 5, 5, 5, 5, 5};
        for (int i = 0; i < 8; i++)
            frame(seq4[i], (i == 7), (seq4[i] == 6), "reject");
        frame(7, 1'b0, 1'b1, "reject7");

        // Timeout after 20 frameless cycles, then stays idle
        lock(2, "acc2");
        gap(20, 20, "timeout");
        gap(3, 0, "idle_hold");

        // A frame on cycle 20 wins over the timeout
        lock(2, "reacc2");
        gap(19, 0, "pre_frame");
        frame(2, 1'b0, 1'b0, "frame_wins");
        gap(20, 20, "timeout2");

        // Reset mid-run discards the partial run
        do_reset("rst_mid");
        for (int i = 1; i <= 3; i++)
            frame(4, 1'b0, 1'b0, "pre_rst");
        do_reset("rst_mid2");
        for (int i = 1; i <= 5; i++)
            frame(4, (i == 5), 1'b0, "post_rst");

        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, "tail");
        repeat (3) @(negedge clk);
        chk("sb_drain", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
